// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes,
// ALU operation codes, datapath mux selects and the control-word layout.
package riscv_ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned SEL_W    = 2;

   localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
   localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
   localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
   localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
   localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
   localparam logic [STATE_W-1:0] S_EXECR    = 4'd6;
   localparam logic [STATE_W-1:0] S_ALUWB    = 4'd7;
   localparam logic [STATE_W-1:0] S_BEQ      = 4'd8;
   localparam logic [STATE_W-1:0] S_HALT     = 4'd9;

   localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;

   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_ALUOUT = 1'b1;

   typedef struct packed {
      logic             mem_req;
      logic             adr_src;
      logic             ir_write;
      logic             pc_write;
      logic             reg_write;
      logic             mem_write;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] aluop;
      logic             illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: status inputs to the controller and the
// control strobes/selects it drives back.
interface multicycle_control_if;
   import riscv_ctrl_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                mem_req;
   logic                adr_src;
   logic                ir_write;
   logic                pc_write;
   logic                reg_write;
   logic                mem_write;
   logic [SEL_W-1:0]    alu_src_a;
   logic [SEL_W-1:0]    alu_src_b;
   logic [SEL_W-1:0]    result_src;
   logic [SEL_W-1:0]    aluop;
   logic                illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
             alu_src_a, alu_src_b, result_src, aluop, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
             alu_src_a, alu_src_b, result_src, aluop, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller (lw/sw/R-type/beq). Control outputs are
// decoded combinationally from the state register, mem_ready and zero.
module multicycle_control
   import riscv_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master ctrl_if,
   output logic [STATE_W-1:0]   state_o
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   ctrl_t              ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.adr_src    = ADR_PC;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.aluop      = ALUOP_ADD;
            ctrl.result_src = RES_ALU;
            ctrl.ir_write   = ctrl_if.mem_ready;
            ctrl.pc_write   = ctrl_if.mem_ready;
            if (ctrl_if.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.aluop     = ALUOP_ADD;
            case (ctrl_if.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.aluop     = ALUOP_ADD;
            if (ctrl_if.opcode == OP_LW)      state_d = S_MEMREAD;
            else if (ctrl_if.opcode == OP_SW) state_d = S_MEMWRITE;
            else                              state_d = S_HALT;
         end
         S_MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = ADR_ALUOUT;
            if (ctrl_if.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_RDATA;
            ctrl.reg_write  = 1'b1;
            state_d         = S_FETCH;
         end
         S_MEMWRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.adr_src   = ADR_ALUOUT;
            ctrl.mem_write = 1'b1;
            if (ctrl_if.mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.aluop     = ALUOP_FUNCT;
            state_d        = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
            state_d         = S_FETCH;
         end
         S_BEQ: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.aluop      = ALUOP_SUB;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_write   = ctrl_if.zero;
            state_d         = S_FETCH;
         end
         S_HALT: begin
            ctrl.illegal = 1'b1;
            state_d      = S_HALT;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset holds FETCH, whose strobes would otherwise follow mem_ready
      if (!rst_n) ctrl = '0;
   end

   assign ctrl_if.mem_req    = ctrl.mem_req;
   assign ctrl_if.adr_src    = ctrl.adr_src;
   assign ctrl_if.ir_write   = ctrl.ir_write;
   assign ctrl_if.pc_write   = ctrl.pc_write;
   assign ctrl_if.reg_write  = ctrl.reg_write;
   assign ctrl_if.mem_write  = ctrl.mem_write;
   assign ctrl_if.alu_src_a  = ctrl.alu_src_a;
   assign ctrl_if.alu_src_b  = ctrl.alu_src_b;
   assign ctrl_if.result_src = ctrl.result_src;
   assign ctrl_if.aluop      = ctrl.aluop;
   assign ctrl_if.illegal    = ctrl.illegal;
   assign state_o            = state_q;

endmodule
